// File: rtl/bitty_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the run/done core handshake.
interface bitty_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       instruction;
  logic              run;
  logic              done;

  modport master (
    output mem_rd_en, mem_addr, instruction, run,
    input  mem_rdata, done
  );

  modport slave (
    input  mem_rd_en, mem_addr, instruction, run,
    output mem_rdata, done
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/sequencer feeding the bitty core; owns the PC and walks START_ADDR..LAST_ADDR.
// Optional BITTY_FETCH_PREFETCH_EN: speculative read of pc+1 during EXEC so done->run takes one cycle.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | memory read of pc
// LOAD    | capture read data into instruction
// ISSUE   | one-cycle run pulse to the core
// EXEC    | core executing; wait for done
module bitty_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  bitty_fetch_unit_if.master bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               finished
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_EXEC
  } state_t;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              fin_q, fin_d;
  logic              stop_pend_q, stop_pend_d;

  logic at_last;
  logic exec_done;
  logic prog_end;
  logic pf_hit;
  logic pf_rd;

  assign at_last   = (pc_q == LAST_PC);
  assign exec_done = (state_q == S_EXEC) && bus.done;
  // A stop arriving together with done still ends the program after this instruction.
  assign prog_end  = exec_done && (stop_pend_q || stop || at_last);

`ifdef BITTY_FETCH_PREFETCH_EN
  logic        pf_rd_q, pf_rd_d;
  logic        pf_valid_q, pf_valid_d;
  logic        exec_first_q, exec_first_d;
  logic [15:0] pf_buf_q, pf_buf_d;

  assign pf_hit = exec_done && !prog_end && pf_valid_q;
  assign pf_rd  = (state_q == S_EXEC) && exec_first_q && !at_last &&
                  !stop_pend_q && !stop && !bus.done;

  always_comb begin
    pf_rd_d      = pf_rd;
    exec_first_d = (state_q == S_ISSUE);
    pf_buf_d     = pf_buf_q;
    pf_valid_d   = pf_valid_q;
    if (pf_rd_q && (state_q == S_EXEC)) begin
      pf_buf_d   = bus.mem_rdata;
      pf_valid_d = 1'b1;
    end
    // Buffer only lives for one EXEC visit; done or stop consumes/discards it.
    if ((state_q != S_EXEC) || exec_done || stop) begin
      pf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_rd_q      <= 1'b0;
      pf_valid_q   <= 1'b0;
      exec_first_q <= 1'b0;
      pf_buf_q     <= 16'h0000;
    end else begin
      pf_rd_q      <= pf_rd_d;
      pf_valid_q   <= pf_valid_d;
      exec_first_q <= exec_first_d;
      pf_buf_q     <= pf_buf_d;
    end
  end
`else
  assign pf_hit = 1'b0;
  assign pf_rd  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (prog_end)    state_d = S_IDLE;
          else if (pf_hit) state_d = S_ISSUE;
          else             state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en   = (state_q == S_FETCH) || pf_rd;
    bus.mem_addr    = pf_rd ? (pc_q + ADDR_W'(1)) : pc_q;
    bus.run         = (state_q == S_ISSUE);
    bus.instruction = instr_q;
    pc              = pc_q;
    busy            = (state_q != S_IDLE);
    finished        = fin_q;
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    fin_d       = prog_end;
    stop_pend_d = stop_pend_q;

    if ((state_q == S_IDLE) && start) begin
      pc_d = START_PC;
    end else if (exec_done && !prog_end) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    if (state_q == S_LOAD) begin
      instr_d = bus.mem_rdata;
    end
`ifdef BITTY_FETCH_PREFETCH_EN
    if (pf_hit) begin
      instr_d = pf_buf_q;
    end
`endif

    if ((state_q != S_IDLE) && stop) begin
      stop_pend_d = 1'b1;
    end
    if (prog_end) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= START_PC;
      instr_q     <= 16'h0000;
      fin_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fin_q       <= fin_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench: two fetch units (program 0..3 and single-instruction 5..5) with memory and core models.
module tb_bitty_fetch_unit;

`ifdef BITTY_FETCH_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, stop0, start1, stop1;
  logic [7:0] pc0, pc1;
  logic       busy0, busy1, fin0, fin1;

  bitty_fetch_unit_if #(.ADDR_W(8)) bus0 ();
  bitty_fetch_unit_if #(.ADDR_W(8)) bus1 ();

  bitty_fetch_unit #(.ADDR_W(8), .START_ADDR(0), .LAST_ADDR(3)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .stop(stop0),
    .bus(bus0), .pc(pc0), .busy(busy0), .finished(fin0)
  );

  bitty_fetch_unit #(.ADDR_W(8), .START_ADDR(5), .LAST_ADDR(5)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1),
    .bus(bus1), .pc(pc1), .busy(busy1), .finished(fin1)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  logic [7:0]  rd0_log[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int run0_cnt = 0, fin0_cnt = 0, run1_cnt = 0, fin1_cnt = 0;
  int cnt0 = 0, cnt1 = 0;
  int start_cyc0 = 0, last_done0 = 0;
  bit first_pending0 = 1'b0;
  bit extra0 = 1'b0;
  bit dpend0 = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rdata <= mem[bus0.mem_addr];
    if (bus1.mem_rd_en) bus1.mem_rdata <= mem[bus1.mem_addr];
  end

  // Core model + scoreboard for dut0: done 4 cycles after run, optional stray done one cycle later.
  always @(negedge clk) begin
    bus0.done = 1'b0;
    if (!reset) begin
      cnt0   = 0;
      dpend0 = 1'b0;
    end else begin
      if (dpend0) begin
        bus0.done = 1'b1;
        dpend0    = 1'b0;
      end
      if (bus0.mem_rd_en) rd0_log.push_back(bus0.mem_addr);
      if (fin0) fin0_cnt++;
      if (bus0.run) begin
        run0_cnt++;
        if (exp0_q.size() == 0) check_val("run0_extra", exp0_q.size(), 1);
        else check_val("run0_instr", bus0.instruction, exp0_q.pop_front());
        if (first_pending0) begin
          check_val("start_to_run", cyc - start_cyc0, 3);
          first_pending0 = 1'b0;
        end else begin
          check_val("done_to_run", cyc - last_done0, GAP);
        end
        cnt0 = 4;
      end else if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0) begin
          bus0.done  = 1'b1;
          last_done0 = cyc;
          if (extra0) dpend0 = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bus1.done = 1'b0;
    if (!reset) begin
      cnt1 = 0;
    end else begin
      if (fin1) fin1_cnt++;
      if (bus1.run) begin
        run1_cnt++;
        if (exp1_q.size() == 0) check_val("run1_extra", exp1_q.size(), 1);
        else check_val("run1_instr", bus1.instruction, exp1_q.pop_front());
        cnt1 = 2;
      end else if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) bus1.done = 1'b1;
      end
    end
  end

  task automatic wait_fin0(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fin0 && n < max);
    check_val("fin0_seen", fin0, 1);
  endtask

  task automatic wait_run_pc0(input logic [7:0] a, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus0.run && pc0 == a) && n < max);
    check_val("run_pc0_seen", (bus0.run && pc0 == a), 1);
  endtask

  task automatic check_reads(input int n);
    check_val("rd_count", rd0_log.size(), n);
    for (int i = 0; i < n && i < rd0_log.size(); i++) begin
      check_val("rd_addr", rd0_log[i], i);
    end
    rd0_log.delete();
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start_cyc0     = cyc;
    first_pending0 = 1'b1;
    start0         = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run_basic(input bit mid_start);
    int r0, f0;
    rd0_log.delete();
    r0 = run0_cnt;
    f0 = fin0_cnt;
    for (int i = 0; i < 4; i++) exp0_q.push_back(mem[i]);
    pulse_start0();
    if (mid_start) begin
      wait_run_pc0(8'd2, 100);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    wait_fin0(200);
    repeat (4) @(negedge clk);
    check_val("basic_runs", run0_cnt - r0, 4);
    check_val("basic_fin", fin0_cnt - f0, 1);
    check_val("basic_pc", pc0, 3);
    check_val("basic_busy", busy0, 0);
    check_val("basic_q_empty", exp0_q.size(), 0);
    check_reads(4);
  endtask

  initial begin
    int r0, f0, n;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1111 * (i + 1));
    reset  = 1'b0;
    start0 = 1'b0;
    stop0  = 1'b0;
    start1 = 1'b0;
    stop1  = 1'b0;

    #12;
    check_val("rst_pc0", pc0, 0);
    check_val("rst_pc1", pc1, 5);
    check_val("rst_instr0", bus0.instruction, 16'h0000);
    check_val("rst_run0", bus0.run, 0);
    check_val("rst_rd_en0", bus0.mem_rd_en, 0);
    check_val("rst_busy0", busy0, 0);
    check_val("rst_fin0", fin0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_val("idle_no_read", rd0_log.size(), 0);
    check_val("idle_busy", busy0, 0);
    check_val("idle_pc0", pc0, 0);

    run_basic(1'b0);

    // Stray done after each real one plus a start while busy.
    extra0 = 1'b1;
    run_basic(1'b1);
    extra0 = 1'b0;

    rd0_log.delete();
    r0 = run0_cnt;
    f0 = fin0_cnt;
    exp0_q.push_back(mem[0]);
    exp0_q.push_back(mem[1]);
    pulse_start0();
    wait_run_pc0(8'd1, 100);
    @(negedge clk);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    wait_fin0(200);
    repeat (8) @(negedge clk);
    check_val("stop_runs", run0_cnt - r0, 2);
    check_val("stop_fin", fin0_cnt - f0, 1);
    check_val("stop_pc", pc0, 1);
    check_val("stop_busy", busy0, 0);
    check_reads(2);

    exp1_q.push_back(mem[5]);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!fin1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("fin1_seen", fin1, 1);
    repeat (5) @(negedge clk);
    check_val("one_runs", run1_cnt, 1);
    check_val("one_fin", fin1_cnt, 1);
    check_val("one_instr", bus1.instruction, 16'h6666);
    check_val("one_pc", pc1, 5);
    check_val("one_busy", busy1, 0);

    for (int i = 0; i < 4; i++) exp0_q.push_back(mem[i]);
    pulse_start0();
    wait_run_pc0(8'd1, 100);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("arst_busy", busy0, 0);
    check_val("arst_run", bus0.run, 0);
    check_val("arst_pc", pc0, 0);
    check_val("arst_instr", bus0.instruction, 16'h0000);
    f0 = fin0_cnt;
    repeat (3) @(negedge clk);
    exp0_q.delete();
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_val("arst_no_fin", fin0_cnt, f0);
    check_val("arst_idle", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
